// File: rtl/phase_meas_pkg.sv
// phase_meas_pkg: shared constants for the phase measurement sequencer.
// Holds the FSM state codes, the default widths and the derived width helpers.
package phase_meas_pkg;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_NSAMP_LOG2 = 4;

    // sample = posedge count + negedge count, one carry bit wider
    localparam int SAMP_W = DEF_CNT_W + 1;
    localparam int SUM_W  = SAMP_W + DEF_NSAMP_LOG2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOW = 3'd1;
    localparam logic [2:0] ST_FIRE     = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

endpackage

// File: rtl/phase_meas_ctrl_if.sv
// phase_meas_ctrl_if: control-register side of the sequencer.
// master (register block): drives go/abort; slave (sequencer): drives busy/done/res_*.
interface phase_meas_ctrl_if
    import phase_meas_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NSAMP_LOG2 = DEF_NSAMP_LOG2
);

    logic                        go;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic [CNT_W+NSAMP_LOG2:0]   res_sum;
    logic [CNT_W:0]              res_min;
    logic [CNT_W:0]              res_max;
    logic [NSAMP_LOG2:0]         res_nvalid;
    logic [NSAMP_LOG2:0]         res_ntimeout;

    modport master (
        output go, abort,
        input  busy, done, res_sum, res_min, res_max, res_nvalid, res_ntimeout
    );

    modport slave (
        input  go, abort,
        output busy, done, res_sum, res_min, res_max, res_nvalid, res_ntimeout
    );

endinterface

// File: rtl/phase_meas_stats.sv
// phase_meas_stats: running sum/min/max/count of valid delay samples.
// Ports: clk_fast, rstn (sync, active-low), clr, smp strobes, value in; sum/smin/smax/nvalid out.
module phase_meas_stats
    import phase_meas_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NSAMP_LOG2 = DEF_NSAMP_LOG2
) (
    input  logic                      clk_fast,
    input  logic                      rstn,
    input  logic                      clr,
    input  logic                      smp,
    input  logic [CNT_W:0]            value,
    output logic [CNT_W+NSAMP_LOG2:0] sum,
    output logic [CNT_W:0]            smin,
    output logic [CNT_W:0]            smax,
    output logic [NSAMP_LOG2:0]       nvalid
);

    localparam logic [NSAMP_LOG2:0] ONE_N = {{NSAMP_LOG2{1'b0}}, 1'b1};

    always_ff @(posedge clk_fast) begin
        if (!rstn || clr) begin
            sum    <= '0;
            smin   <= '1;
            smax   <= '0;
            nvalid <= '0;
        end else if (smp) begin
            sum    <= sum + {{NSAMP_LOG2{1'b0}}, value};
            nvalid <= nvalid + ONE_N;
            if (value < smin) smin <= value;
            if (value > smax) smax <= value;
        end
    end

endmodule

// File: rtl/phase_meas_ctrl.sv
// phase_meas_ctrl: fires start pulses at the phase detector, waits for the echo,
// samples phase_diff after settling and accumulates stats over 2^NSAMP_LOG2 attempts.
// Ports: clk_fast, rstn (sync, active-low), regs (slave: go/abort in, busy/done/res_* out),
//        stop_i (echo), pd_phase_diff (detector counts), start_o (to detector).
module phase_meas_ctrl
    import phase_meas_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NSAMP_LOG2 = DEF_NSAMP_LOG2,
    parameter int TIMEOUT    = 200,
    parameter int START_LEN  = 2,
    parameter int GAP        = 8
) (
    input  logic                 clk_fast,
    input  logic                 rstn,
    phase_meas_ctrl_if.slave     regs,
    input  logic                 stop_i,
    input  logic [2*CNT_W-1:0]   pd_phase_diff,
    output logic                 start_o
);

    // one shared down-counter; each load value gives that many cycles in-state
    localparam logic [15:0] TO_LD  = 16'(TIMEOUT - 1);
    localparam logic [15:0] ST_LD  = 16'(START_LEN - 1);
    localparam logic [15:0] GAP_LD = 16'(GAP - 1);
    localparam logic [15:0] SET_LD = 16'd1;

    localparam logic [NSAMP_LOG2:0] ONE_N = {{NSAMP_LOG2{1'b0}}, 1'b1};
    localparam logic [NSAMP_LOG2:0] LAST  = (NSAMP_LOG2+1)'((1 << NSAMP_LOG2) - 1);

    logic [2:0]          state;
    logic [15:0]         cnt;
    logic [NSAMP_LOG2:0] attempts;
    logic [NSAMP_LOG2:0] ntimeout;
    logic                stop_q;
    logic                busy;
    logic                done;
    logic                stop_rise;
    logic                cnt_zero;
    logic                clr;
    logic                smp;
    logic [CNT_W:0]      value;

    assign stop_rise = stop_i & ~stop_q;
    assign cnt_zero  = (cnt == 16'd0);

    assign clr = (state == ST_IDLE) && regs.go && !regs.abort;
    assign smp = (state == ST_SETTLE) && cnt_zero && !regs.abort;

    assign value = {1'b0, pd_phase_diff[CNT_W-1:0]}
                 + {1'b0, pd_phase_diff[2*CNT_W-1:CNT_W]};

    always_ff @(posedge clk_fast) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            attempts <= '0;
            ntimeout <= '0;
            stop_q   <= 1'b0;
            start_o  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            stop_q <= stop_i;
            done   <= 1'b0;
            if (regs.abort && state != ST_IDLE) begin
                state   <= ST_IDLE;
                start_o <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (regs.go && !regs.abort) begin
                            attempts <= '0;
                            ntimeout <= '0;
                            busy     <= 1'b1;
                            cnt      <= TO_LD;
                            state    <= ST_WAIT_LOW;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (!stop_i) begin
                            start_o <= 1'b1;
                            cnt     <= ST_LD;
                            state   <= ST_FIRE;
                        end else if (cnt_zero) begin
                            ntimeout <= ntimeout + ONE_N;
                            cnt      <= GAP_LD;
                            state    <= ST_GAP;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_FIRE: begin
                        if (stop_rise) begin
                            start_o <= 1'b0;
                            cnt     <= SET_LD;
                            state   <= ST_SETTLE;
                        end else if (cnt_zero) begin
                            start_o <= 1'b0;
                            cnt     <= TO_LD;
                            state   <= ST_WAIT;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_WAIT: begin
                        // an edge on the last count cycle beats the timeout
                        if (stop_rise) begin
                            cnt   <= SET_LD;
                            state <= ST_SETTLE;
                        end else if (cnt_zero) begin
                            ntimeout <= ntimeout + ONE_N;
                            cnt      <= GAP_LD;
                            state    <= ST_GAP;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_SETTLE: begin
                        // two cycles: detector posedge then negedge capture
                        if (cnt_zero) begin
                            cnt   <= GAP_LD;
                            state <= ST_GAP;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_zero) begin
                            attempts <= attempts + ONE_N;
                            if (attempts == LAST) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                cnt   <= TO_LD;
                                state <= ST_WAIT_LOW;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign regs.busy         = busy;
    assign regs.done         = done;
    assign regs.res_ntimeout = ntimeout;

    phase_meas_stats #(
        .CNT_W      (CNT_W),
        .NSAMP_LOG2 (NSAMP_LOG2)
    ) u_stats (
        .clk_fast (clk_fast),
        .rstn     (rstn),
        .clr      (clr),
        .smp      (smp),
        .value    (value),
        .sum      (regs.res_sum),
        .smin     (regs.res_min),
        .smax     (regs.res_max),
        .nvalid   (regs.res_nvalid)
    );

endmodule

// File: tb/tb_phase_meas_ctrl.sv
// tb_phase_meas_ctrl: directed bench for phase_meas_ctrl with an echo/detector model.
// Echo: stop rises D cycles after start, held 4; detector bytes posedge=D+1, negedge=D.
module tb_phase_meas_ctrl;
    import phase_meas_pkg::*;

    logic        clk_fast = 1'b0;
    logic        rstn;
    logic        stop_i;
    logic [15:0] pd_phase_diff;
    logic        start_o;

    phase_meas_ctrl_if #(.CNT_W(8), .NSAMP_LOG2(4)) regs ();

    phase_meas_ctrl #(
        .CNT_W(8), .NSAMP_LOG2(4), .TIMEOUT(200), .START_LEN(2), .GAP(8)
    ) dut (
        .clk_fast      (clk_fast),
        .rstn          (rstn),
        .regs          (regs),
        .stop_i        (stop_i),
        .pd_phase_diff (pd_phase_diff),
        .start_o       (start_o)
    );

    always #5 clk_fast = ~clk_fast;

    int vectors = 0;
    int miscompares = 0;

    bit [15:0] echo_mask = 16'hFFFF;
    int        dly_even = 10;
    int        dly_odd = 10;
    bit        stuck = 1'b0;
    int        echo_idx = 0;
    int        n_start = 0;
    int        done_cnt = 0;
    int        low_len [32];

    // echo + detector model, updated away from the active edge
    initial begin : echo_model
        int  age;
        int  cur_d;
        int  low_cnt;
        bit  armed;
        bit  prev_start;
        bit  lvl;
        age = 0; cur_d = 0; low_cnt = 0; armed = 0; prev_start = 0; lvl = 0;
        stop_i = 1'b0;
        pd_phase_diff = '0;
        forever begin
            @(negedge clk_fast);
            if (start_o === 1'b1 && !prev_start) begin
                if (echo_idx > 0 && echo_idx <= 32) low_len[echo_idx-1] = low_cnt;
                armed = (echo_idx < 16) ? echo_mask[echo_idx[3:0]] : 1'b0;
                cur_d = echo_idx[0] ? dly_odd : dly_even;
                age = 0;
                low_cnt = 0;
                pd_phase_diff = '0;
                echo_idx++;
                n_start++;
            end else begin
                if (start_o === 1'b0) low_cnt++;
                if (armed) begin
                    age++;
                    if (age == cur_d) begin
                        lvl = 1'b1;
                        pd_phase_diff[7:0] = 8'(cur_d + 1);
                    end
                    if (age == cur_d + 2) pd_phase_diff[15:8] = 8'(cur_d);
                    if (age == cur_d + 4) begin
                        lvl = 1'b0;
                        armed = 1'b0;
                    end
                end
            end
            prev_start = (start_o === 1'b1);
            stop_i = stuck ? 1'b1 : lvl;
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk_fast);
            if (regs.done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_fast);
            #1;
        end
    endtask

    task automatic pulse_go();
        regs.go = 1'b1;
        tick(1);
        regs.go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (regs.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_nvalid(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (regs.res_nvalid == 5'(n)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic setup_echo(input bit [15:0] mask, input int de, input int dodd);
        echo_mask = mask;
        dly_even = de;
        dly_odd = dodd;
        echo_idx = 0;
        n_start = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        regs.go = 1'b0;
        regs.abort = 1'b0;
        tick(3);
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %b want 0", start_o); end
        vectors++; if (regs.busy !== 1'b0 || regs.done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done: got %b%b want 00", regs.busy, regs.done); end
        vectors++; if (regs.res_sum !== 13'd0 || regs.res_max !== 9'd0) begin miscompares++; $display("FAIL rst_sum_max: got %0d %0d want 0 0", regs.res_sum, regs.res_max); end
        vectors++; if (regs.res_min !== 9'h1FF) begin miscompares++; $display("FAIL rst_min: got %h want 1ff", regs.res_min); end
        vectors++; if (regs.res_nvalid !== 5'd0 || regs.res_ntimeout !== 5'd0) begin miscompares++; $display("FAIL rst_counts: got %0d %0d want 0 0", regs.res_nvalid, regs.res_ntimeout); end
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_loopback();
        bit ok;
        setup_echo(16'hFFFF, 10, 10);
        pulse_go();
        vectors++; if (regs.busy !== 1'b1) begin miscompares++; $display("FAIL loop_busy: got %b want 1", regs.busy); end
        wait_done(2000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL loop_done: got timeout want done"); end
        vectors++; if (regs.busy !== 1'b0) begin miscompares++; $display("FAIL loop_busy_at_done: got %b want 0", regs.busy); end
        vectors++; if (regs.res_nvalid !== 5'd16 || regs.res_ntimeout !== 5'd0) begin miscompares++; $display("FAIL loop_counts: got %0d/%0d want 16/0", regs.res_nvalid, regs.res_ntimeout); end
        vectors++; if (regs.res_min !== 9'd21 || regs.res_max !== 9'd21) begin miscompares++; $display("FAIL loop_minmax: got %0d/%0d want 21/21", regs.res_min, regs.res_max); end
        vectors++; if (regs.res_sum !== 13'd336) begin miscompares++; $display("FAIL loop_sum: got %0d want 336", regs.res_sum); end
        vectors++; if (low_len[0] != 20) begin miscompares++; $display("FAIL loop_period: got %0d want 20", low_len[0]); end
        vectors++; if (n_start != 16) begin miscompares++; $display("FAIL loop_nstart: got %0d want 16", n_start); end
        tick(1);
        vectors++; if (regs.done !== 1'b0) begin miscompares++; $display("FAIL loop_done_pulse: got %b want 0", regs.done); end
        tick(10);
    endtask

    task automatic test_timeouts();
        bit ok;
        setup_echo(16'hFFBB, 10, 10);
        pulse_go();
        wait_done(3000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_done: got timeout want done"); end
        vectors++; if (regs.res_ntimeout !== 5'd2 || regs.res_nvalid !== 5'd14) begin miscompares++; $display("FAIL to_counts: got %0d/%0d want 2/14", regs.res_ntimeout, regs.res_nvalid); end
        vectors++; if (regs.res_sum !== 13'd294) begin miscompares++; $display("FAIL to_sum: got %0d want 294", regs.res_sum); end
        vectors++; if (low_len[2] != 209 || low_len[6] != 209) begin miscompares++; $display("FAIL to_wait_len: got %0d/%0d want 209/209", low_len[2], low_len[6]); end
        vectors++; if (low_len[3] != 20) begin miscompares++; $display("FAIL to_valid_len: got %0d want 20", low_len[3]); end
        tick(10);
    endtask

    task automatic test_alternating();
        bit ok;
        setup_echo(16'hFFFF, 5, 12);
        pulse_go();
        wait_done(2000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL alt_done: got timeout want done"); end
        vectors++; if (regs.res_min !== 9'd11 || regs.res_max !== 9'd25) begin miscompares++; $display("FAIL alt_minmax: got %0d/%0d want 11/25", regs.res_min, regs.res_max); end
        vectors++; if (regs.res_sum !== 13'd288 || regs.res_nvalid !== 5'd16) begin miscompares++; $display("FAIL alt_sum: got %0d/%0d want 288/16", regs.res_sum, regs.res_nvalid); end
        tick(10);
    endtask

    task automatic test_stuck();
        bit ok;
        int d0;
        setup_echo(16'hFFFF, 10, 10);
        stuck = 1'b1;
        tick(3);
        d0 = done_cnt;
        pulse_go();
        wait_done(5000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stuck_done: got timeout want done"); end
        vectors++; if (regs.res_ntimeout !== 5'd16 || regs.res_nvalid !== 5'd0) begin miscompares++; $display("FAIL stuck_counts: got %0d/%0d want 16/0", regs.res_ntimeout, regs.res_nvalid); end
        vectors++; if (regs.res_min !== 9'h1FF || regs.res_max !== 9'd0) begin miscompares++; $display("FAIL stuck_minmax: got %h/%h want 1ff/000", regs.res_min, regs.res_max); end
        vectors++; if (n_start != 0) begin miscompares++; $display("FAIL stuck_nostart: got %0d want 0", n_start); end
        tick(3);
        vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL stuck_done_cnt: got %0d want 1", done_cnt - d0); end
        stuck = 1'b0;
        tick(10);
    endtask

    task automatic test_busy_go_abort();
        bit ok;
        int d0;
        setup_echo(16'hFFFF, 10, 10);
        d0 = done_cnt;
        pulse_go();
        wait_nvalid(1, 500, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ab_first: got timeout want nvalid 1"); end
        pulse_go();
        vectors++; if (regs.res_nvalid !== 5'd1 || regs.busy !== 1'b1) begin miscompares++; $display("FAIL ab_go_ignored: got %0d/%b want 1/1", regs.res_nvalid, regs.busy); end
        wait_nvalid(3, 500, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ab_third: got timeout want nvalid 3"); end
        regs.abort = 1'b1;
        tick(1);
        regs.abort = 1'b0;
        vectors++; if (regs.busy !== 1'b0 || start_o !== 1'b0) begin miscompares++; $display("FAIL ab_stop: got %b/%b want 0/0", regs.busy, start_o); end
        vectors++; if (regs.res_nvalid !== 5'd3 || regs.res_sum !== 13'd63) begin miscompares++; $display("FAIL ab_partial: got %0d/%0d want 3/63", regs.res_nvalid, regs.res_sum); end
        tick(40);
        vectors++; if (done_cnt != d0 || regs.busy !== 1'b0 || start_o !== 1'b0) begin miscompares++; $display("FAIL ab_quiet: got done %0d busy %b start %b want 0 0 0", done_cnt - d0, regs.busy, start_o); end
    endtask

    task automatic test_go_abort_same();
        int s0;
        s0 = n_start;
        regs.go = 1'b1;
        regs.abort = 1'b1;
        tick(1);
        regs.go = 1'b0;
        regs.abort = 1'b0;
        vectors++; if (regs.busy !== 1'b0) begin miscompares++; $display("FAIL ga_busy: got %b want 0", regs.busy); end
        tick(20);
        vectors++; if (n_start != s0 || regs.res_nvalid !== 5'd3) begin miscompares++; $display("FAIL ga_norun: got %0d starts nvalid %0d want 0 3", n_start - s0, regs.res_nvalid); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        setup_echo(16'hFFFF, 10, 10);
        pulse_go();
        wait_nvalid(2, 500, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (start_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_fire: got timeout want start_o"); end
        rstn = 1'b0;
        tick(1);
        vectors++; if (start_o !== 1'b0 || regs.busy !== 1'b0) begin miscompares++; $display("FAIL rm_out: got %b/%b want 0/0", start_o, regs.busy); end
        vectors++; if (regs.res_nvalid !== 5'd0 || regs.res_sum !== 13'd0 || regs.res_min !== 9'h1FF) begin miscompares++; $display("FAIL rm_res: got %0d/%0d/%h want 0/0/1ff", regs.res_nvalid, regs.res_sum, regs.res_min); end
        rstn = 1'b1;
        tick(20);
        setup_echo(16'hFFFF, 10, 10);
        pulse_go();
        wait_done(2000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_done: got timeout want done"); end
        vectors++; if (regs.res_nvalid !== 5'd16 || regs.res_sum !== 13'd336) begin miscompares++; $display("FAIL rm_rerun: got %0d/%0d want 16/336", regs.res_nvalid, regs.res_sum); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_timeouts();
        test_alternating();
        test_stuck();
        test_busy_go_abort();
        test_go_abort_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_meas_ctrl.md
Name: phase_meas_ctrl

Overview:
- Sequencer that drives the `start` input of the `phase_detector` round-trip counter.
- Flow per run: fires a start pulse, waits for the echo (`stop`), lets the detector's posedge and negedge capture registers settle, then samples `phase_diff`.
- Repeats for 2^NSAMP_LOG2 attempts per run and reports sum/min/max of the half-cycle-resolution delay, plus a timeout count.
- Sits between the control register block (go/abort, results) and the detector, on the `clk_fast` domain.

Parameters:
- CNT_W, 8: width of each detector half-count (must match detector byte width).
- NSAMP_LOG2, 4: log2 of attempts per run (16).
- TIMEOUT, 200: max cycles in WAIT/WAIT_LOW before an attempt is declared lost; range 2..65535.
- START_LEN, 2: start pulse width in cycles; range 1..15.
- GAP, 8: idle cycles between attempts (echo line recovery); range 1..255.

Ports:
- clk_fast  in  1  sole clock; same clock as `phase_detector`.
- rstn  in  1  synchronous, active-low reset.
- go  in  1  single-cycle run request; ignored unless busy=0.
- abort  in  1  single-cycle; terminates the run without done.
- stop_i  in  1  echo signal, already synchronous to clk_fast; same net as detector `stop`.
- pd_phase_diff  in  2*CNT_W  detector output: [CNT_W-1:0] posedge count, upper byte negedge count.
- start_o  out  1  to detector `start`.
- busy  out  1  high from the cycle after an accepted go until DONE/abort.
- done  out  1  one-cycle pulse; results are stable from this cycle on.
- res_sum  out  CNT_W+1+NSAMP_LOG2  sum of valid samples.
- res_min  out  CNT_W+1  minimum valid sample.
- res_max  out  CNT_W+1  maximum valid sample.
- res_nvalid  out  NSAMP_LOG2+1  count of valid samples.
- res_ntimeout  out  NSAMP_LOG2+1  count of timed-out attempts.

Behaviour:
- Reset values:
  - start_o=0, busy=0, done=0.
  - res_sum=0, res_min=all-ones, res_max=0, res_nvalid=0, res_ntimeout=0.
  - FSM in IDLE; stop_q=0.
- Edge detect: stop_q <= stop_i every cycle; stop_rise = stop_i & ~stop_q.
- Sample value: pd_phase_diff[CNT_W-1:0] + pd_phase_diff[2*CNT_W-1:CNT_W], zero-extended to CNT_W+1 bits. No saturation; the detector's own wrap is the caller's concern.
- IDLE, on go:
  - Clear all res_* to their reset values.
  - Clear attempt counter; busy=1 next cycle.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - If stop_i=0, go to FIRE next cycle.
  - Else count; on reaching TIMEOUT cycles, the attempt is a timeout (res_ntimeout+1) and the FSM goes to GAP.
- FIRE:
  - start_o=1 for exactly START_LEN cycles, then go to WAIT.
  - A stop_rise during FIRE drops start_o the same cycle (registered: deasserted from the next cycle) and goes to SETTLE.
- WAIT:
  - start_o=0; timeout counter starts at 0 on entry.
  - stop_rise goes to SETTLE.
  - Counter reaching TIMEOUT-1 with no edge is a timeout (res_ntimeout+1) and goes to GAP.
  - An edge on the final count cycle wins over the timeout.
- SETTLE:
  - Exactly 2 cycles. This covers the detector's posedge capture and the following negedge capture.
  - On the cycle leaving SETTLE, latch the sample: res_sum+=v, res_min=min, res_max=max, res_nvalid+1.
  - Then go to GAP.
- GAP:
  - Hold GAP cycles; increment the attempt counter.
  - If attempts == 2^NSAMP_LOG2, go to DONE; else go to WAIT_LOW.
- DONE: done=1 for one cycle, busy=0 the same cycle, then IDLE.
- Total attempts per run is always 2^NSAMP_LOG2, so res_nvalid + res_ntimeout = 2^NSAMP_LOG2 at done.
- abort (any non-IDLE state):
  - Next cycle: IDLE, start_o=0, busy=0, no done pulse.
  - res_* hold their partial values.
  - abort has priority over all transitions.
- go while busy: ignored. go and abort in the same cycle in IDLE: abort wins, no run.
- If res_nvalid=0 at done, res_min stays all-ones and res_max stays 0. Software flags this condition.
- Reset mid-run: all outputs return to reset values on the next clock edge; start_o must never stay high across reset.
- Latency (all valid, delay D cycles from first start_o cycle to stop_rise, D ≥ START_LEN): per attempt ≈ 1 + D + 2 + GAP cycles.

Decomposition:
- Shared package `phase_meas_pkg`:
  - FSM state enum: IDLE, WAIT_LOW, FIRE, WAIT, SETTLE, GAP, DONE.
  - Width helper constants SAMP_W = CNT_W+1 and SUM_W = SAMP_W+NSAMP_LOG2.
- One sub-module: `phase_meas_stats`. Accumulates sum/min/max/nvalid on a sample strobe and clears on a clear strobe.
- Timeout/gap/start counters are a single shared down-counter in the FSM module.

Test Plan:
- Loopback model: stop = start delayed 10 cycles and held 4 cycles; defaults; go. Required: done after 16 attempts; res_nvalid=16; res_ntimeout=0; res_min=res_max=sample; res_sum=16*sample; sample = posedge + negedge counts (~20–21).
- Echo absent on attempts 3 and 7 → res_ntimeout=2, res_nvalid=14, res_sum=14*sample. Each timed-out WAIT lasts exactly 200 cycles.
- stop_i stuck high → start_o never asserts; 16 timeouts; res_nvalid=0; res_min=0x1FF; res_max=0; done pulses.
- Delay alternating 5/12 cycles → res_min and res_max match the detector readings for 5 and 12; res_sum = 8*(v5+v12).
- go pulsed again while busy, and abort after 3 attempts → second go ignored; abort gives busy=0 with no done pulse, res_nvalid=3, start_o=0.
- rstn low for 1 cycle during FIRE → next cycle start_o=0 and all res_* at reset values; a fresh go then completes normally.
